// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// Results appear all at once when the busy timer expires; HI/LO never show partial values.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | accepting requests; MTHI/MTLO write HI/LO immediately
//  ST_BUSY | op in flight, down-counter running; commit on 1 -> 0 edge
module mult_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDsel,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   op_a, op_a_nxt;
    logic [WIDTH-1:0]   op_b, op_b_nxt;
    logic               op_div, op_div_nxt;
    logic               op_signed, op_signed_nxt;
    logic [WIDTH-1:0]   hi_q, hi_nxt;
    logic [WIDTH-1:0]   lo_q, lo_nxt;

    // Datapath works on the latched operands only, so A/B may change freely while busy.
    logic [2*WIDTH-1:0] mul_a, mul_b, product;
    logic               neg_a, neg_b, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b, div_by;
    logic [WIDTH-1:0]   quo_mag, rem_mag, quo, rem;

    assign mul_a   = op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    assign mul_b   = op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    assign product = mul_a * mul_b;

    // Sign-magnitude division: most-negative / -1 wraps back to most-negative with zero remainder.
    assign neg_a    = op_signed & op_a[WIDTH-1];
    assign neg_b    = op_signed & op_b[WIDTH-1];
    assign mag_a    = neg_a ? (WIDTH'(0) - op_a) : op_a;
    assign mag_b    = neg_b ? (WIDTH'(0) - op_b) : op_b;
    assign div_zero = (op_b == '0);
    assign div_by   = div_zero ? WIDTH'(1) : mag_b;
    assign quo_mag  = mag_a / div_by;
    assign rem_mag  = mag_a % div_by;
    assign quo      = (neg_a ^ neg_b) ? (WIDTH'(0) - quo_mag) : quo_mag;
    assign rem      = neg_a ? (WIDTH'(0) - rem_mag) : rem_mag;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        op_div_nxt    = op_div;
        op_signed_nxt = op_signed;
        hi_nxt        = hi_q;
        lo_nxt        = lo_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (MDsel)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_nxt     = ST_BUSY;
                            op_a_nxt      = A;
                            op_b_nxt      = B;
                            op_div_nxt    = (MDsel == OP_DIV) || (MDsel == OP_DIVU);
                            op_signed_nxt = (MDsel == OP_MULT) || (MDsel == OP_DIV);
                            cnt_nxt       = ((MDsel == OP_DIV) || (MDsel == OP_DIVU))
                                            ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                        end
                        OP_MTHI: hi_nxt = A;
                        OP_MTLO: lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    if (!op_div) begin
                        hi_nxt = product[2*WIDTH-1:WIDTH];
                        lo_nxt = product[WIDTH-1:0];
                    end else if (!div_zero) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            op_div    <= op_div_nxt;
            op_signed <= op_signed_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
        end
    end

    assign busy = (state == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at accept, popped when busy drops.
module tb_mult_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  MDsel;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] exp_q[$];

    mult_div_unit #(.WIDTH(32), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDsel(MDsel), .start(start),
        .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_result(input logic [2:0] sel, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (sel)
            3'd1: return sa * sb;
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {hi, lo};
                return {a % b, a / b};
            end
            3'd5: return {a, lo};
            3'd6: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    // Caller is just past a negedge; returns just past the negedge of the first idle cycle.
    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input bit fixed, input logic [31:0] fhi, input logic [31:0] flo,
                          input string name);
        logic [63:0] e;
        int cyc, n;
        bit held;
        MDsel = sel; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        e = fixed ? {fhi, flo} : ref_result(sel, a, b, model_hi, model_lo);
        exp_q.push_back(e);
        if (sel == 3'd5 || sel == 3'd6) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL %s busy: got %b want 0", name, busy);
            end
        end else begin
            n = (sel <= 3'd2) ? MUL_N : DIV_N;
            cyc = 0; held = 1'b1;
            @(negedge clk);
            while (busy === 1'b1 && cyc < 40) begin
                if (HI !== model_hi || LO !== model_lo) held = 1'b0;
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (cyc != n) begin
                errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, n);
            end
            checks++;
            if (!held) begin
                errors++; $display("FAIL %s hold: HI/LO changed while busy, want %h/%h", name, model_hi, model_lo);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (HI !== e[63:32]) begin
            errors++; $display("FAIL %s HI: got %h want %h", name, HI, e[63:32]);
        end
        checks++;
        if (LO !== e[31:0]) begin
            errors++; $display("FAIL %s LO: got %h want %h", name, LO, e[31:0]);
        end
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; MDsel = 3'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset HI: got %h want 0", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset LO: got %h want 0", LO); end
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        run_op(3'd5, 32'hCAFEF00D, 32'h0, 1'b1, 32'hCAFEF00D, 32'h0, "mthi_pre");
        reset = 1'b1; start = 1'b1; MDsel = 3'd6; A = 32'h55;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_prio HI: got %h want 0", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_prio LO: got %h want 0", LO); end
        model_hi = '0; model_lo = '0;
    endtask

    task automatic test_mult();
        run_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        run_op(3'd2, 32'hFFFFFFFF, 32'h2, 1'b1, 32'h00000001, 32'hFFFFFFFE, "multu");
    endtask

    task automatic test_div();
        run_op(3'd3, 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        run_op(3'd4, 32'hFFFFFFF9, 32'h2, 1'b1, 32'h00000001, 32'h7FFFFFFC, "divu");
        run_op(3'd3, 32'd7, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, "div_negdivisor");
    endtask

    task automatic test_mt_divzero();
        run_op(3'd5, 32'h12345678, 32'h0, 1'b1, 32'h12345678, model_lo, "mthi");
        run_op(3'd6, 32'h9ABCDEF0, 32'h0, 1'b1, 32'h12345678, 32'h9ABCDEF0, "mtlo");
        run_op(3'd4, 32'h11111111, 32'h0, 1'b1, 32'h12345678, 32'h9ABCDEF0, "divu_zero");
        run_op(3'd3, 32'h80000001, 32'h0, 1'b1, 32'h12345678, 32'h9ABCDEF0, "div_zero");
    endtask

    task automatic test_div_overflow();
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, "div_ovf");
    endtask

    task automatic test_busy_ignore();
        logic [63:0] e;
        bit busy_ok;
        busy_ok = 1'b1;
        MDsel = 3'd1; A = 32'h3; B = 32'hFFFFFFFE; start = 1'b1;
        e = ref_result(3'd1, 32'h3, 32'hFFFFFFFE, model_hi, model_lo);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= MUL_N; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (c == 2) begin
                MDsel = 3'd6; A = 32'h1; start = 1'b1;
            end else if (c == 4) begin
                MDsel = 3'd4; A = 32'h100; B = 32'h3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (!busy_ok || busy !== 1'b0) begin
            errors++; $display("FAIL ignore busy_window: got busy=%b ok=%b want 0 after %0d cycles", busy, busy_ok, MUL_N);
        end
        e = exp_q.pop_front();
        checks++; if (HI !== e[63:32]) begin errors++; $display("FAIL ignore HI: got %h want %h", HI, e[63:32]); end
        checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL ignore LO: got %h want %h", LO, e[31:0]); end
        checks++; if (LO === 32'h1) begin errors++; $display("FAIL ignore mtlo_leak: got LO=%h want not 00000001", LO); end
        model_hi = e[63:32]; model_lo = e[31:0];
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 32'h0, "b2b_multu");
        run_op(3'd3, 32'hFFFFFF9C, 32'd7, 1'b0, 32'h0, 32'h0, "b2b_div");
        run_op(3'd6, 32'hA5A5A5A5, 32'h0, 1'b0, 32'h0, 32'h0, "b2b_mtlo");
        run_op(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, "b2b_mult");
    endtask

    task automatic test_reserved();
        logic [2:0] sels [2];
        sels[0] = 3'd0; sels[1] = 3'd7;
        for (int i = 0; i < 2; i++) begin
            MDsel = sels[i]; A = $urandom; B = $urandom | 32'h1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved%0d busy: got %b want 0", i, busy); end
            checks++;
            if (HI !== model_hi || LO !== model_lo) begin
                errors++; $display("FAIL reserved%0d hilo: got %h/%h want %h/%h", i, HI, LO, model_hi, model_lo);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] sel;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            sel = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(20, 31);
            if ((sel == 3'd3 || sel == 3'd4) && $urandom_range(0, 7) == 0) b = '0;
            run_op(sel, a, b, 1'b0, 32'h0, 32'h0, "random");
        end
    endtask

    task automatic test_reset_abort();
        bit busy_ok, stayed;
        busy_ok = 1'b1; stayed = 1'b1;
        run_op(3'd5, 32'hDEADBEEF, 32'h0, 1'b1, 32'hDEADBEEF, model_lo, "abort_pre");
        MDsel = 3'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (!busy_ok) begin errors++; $display("FAIL abort busy_before: busy low before reset, want 1"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL abort HI: got %h want 0", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL abort LO: got %h want 0", LO); end
        model_hi = '0; model_lo = '0;
        repeat (DIV_N + 4) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin
            errors++; $display("FAIL abort late_commit: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_divzero();
        test_div_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reserved();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 Parameter MUL_CYCLES, default 5, busy cycles for multiply ops, legal range >=1.
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide ops, legal range >=1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 A  input  WIDTH  operand 1 (multiplicand / dividend / MTHI-MTLO source).
REQ-007 B  input  WIDTH  operand 2 (multiplier / divisor).
REQ-008 MDsel  input  3  op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-009 start  input  1  op request qualifier, sampled on rising edge.
REQ-010 busy  output  1  registered; high while a multiply/divide is in progress.
REQ-011 HI  output  WIDTH  registered HI register.
REQ-012 LO  output  WIDTH  registered LO register.

Function
REQ-013 Request accepted at an edge iff start=1, busy=0, reset=0, MDsel in 1..6; otherwise no state change.
REQ-014 MULT/MULTU/DIV/DIVU accept: latch A, B, op; load down-counter with MUL_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
REQ-015 busy stays 1 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES); counter decrements each edge.
REQ-016 At the edge where counter goes 1->0: HI/LO commit result and busy drops to 0; new HI/LO visible in the first cycle busy=0.
REQ-017 HI/LO hold their old values throughout busy; no intermediate values visible.
REQ-018 MULT: signed 2*WIDTH product, HI=upper WIDTH bits, LO=lower WIDTH bits; MULTU: same, unsigned.
REQ-019 DIV: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend; DIVU: unsigned.
REQ-020 DIV of most-negative value by -1: LO=most-negative value, HI=0, no error.
REQ-021 Divisor 0 (DIV or DIVU): busy asserted for DIV_CYCLES as normal; HI and LO unchanged at commit.
REQ-022 MTHI/MTLO accept: HI (resp. LO) <= A at that edge; busy not asserted; other register unchanged.
REQ-023 Any request (including MTHI/MTLO) with start=1 while busy=1 is ignored; in-flight op unaffected; no queuing.
REQ-024 A new op is acceptable in the first cycle busy=0 (back-to-back with one-cycle-visible result).
REQ-025 MDsel 0 or 7 with start=1: ignored.
REQ-026 A/B changes after accept do not affect the in-flight result.

Reset
REQ-027 reset=1 at an edge: HI=0, LO=0, busy=0, counter=0, latched operands discarded.
REQ-028 reset has priority over start and over a commit at the same edge.
REQ-029 reset mid-operation aborts the op; no partial or later commit occurs.

Verification (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10)
REQ-030 MULT A=0xFFFFFFFF B=2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-031 DIV A=0xFFFFFFF9 B=2 -> busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU same -> LO=0x7FFFFFFC HI=0x00000001.
REQ-032 MTHI A=0x12345678, MTLO A=0x9ABCDEF0, then DIVU B=0 -> busy 10 cycles, HI=0x12345678 LO=0x9ABCDEF0 after.
REQ-033 DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0x00000000.
REQ-034 MULT accepted, then start with MTLO A=0x1 and DIVU at busy cycles 2 and 4 -> both ignored; only MULT result commits at cycle 5; LO not 0x1.
REQ-035 DIV accepted, reset pulsed at busy cycle 3 -> next cycle busy=0 HI=0 LO=0; no commit ever follows.
